// File: rtl/axis_vid_frame_aligner_pkg.sv
// Shared video definitions: checker state encoding and default 1080p geometry.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package axis_vid_frame_aligner_pkg;

  localparam int VID_DATA_WIDTH = 16;
  localparam int VID_H_ACTIVE   = 1920;
  localparam int VID_V_ACTIVE   = 1080;

  // SYNC: hunting for a start-of-frame beat; PASS: locked to the frame grid.
  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_PASS = 1'b1
  } vid_state_t;

  // Counter width for a 0..n-1 counter; never narrower than one bit.
  function automatic int vid_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_vid_frame_aligner_if.sv
// AXI4-Stream video bundle (pixel, keep, end-of-line, start-of-frame, handshake).
// Latency: n/a (wiring only).
// Backpressure: tready flows from slave to master.
// Ports: master drives tdata/tkeep/tlast/tuser/tvalid; slave drives tready.
interface axis_vid_frame_aligner_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tuser;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/axis_vid_frame_aligner_skid_buf.sv
// Two-entry skid buffer carrying one stream beat payload.
// Latency: one cycle from push to o_vld; one beat per cycle with i_rdy held high.
// Backpressure: o_rdy is registered and drops only when both entries are occupied.
// Ports: aclk/resetn; upstream i_vld/i_dat/o_rdy; downstream o_vld/o_dat/i_rdy.
module axis_skid_buf #(
  parameter int W = 18
) (
  input  logic         aclk,
  input  logic         resetn,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_rdy,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  input  logic         i_rdy
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;
  logic         r_rdy;

  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_cnt_nxt;

  assign w_push    = i_vld & r_rdy;
  assign w_pop     = (r_cnt != 2'd0) & i_rdy;
  assign w_cnt_nxt = r_cnt + 2'(w_push) - 2'(w_pop);

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
      r_rdy    <= 1'b0;
    end else begin
      // With one entry held, the write pointer never equals the read pointer,
      // so the presented beat stays stable while the sink stalls.
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt <= w_cnt_nxt;
      // Ready is computed from next occupancy so it is exact yet registered.
      r_rdy <= (w_cnt_nxt != 2'd2);
    end
  end

  assign o_rdy = r_rdy;
  assign o_vld = (r_cnt != 2'd0);
  assign o_dat = r_mem[r_rd_ptr];

endmodule

// File: rtl/axis_vid_frame_aligner.sv
// Video frame aligner: checks geometry, regenerates tlast/tuser, drops beats until next SOF on error.
// Latency: one cycle from input acceptance to m_axis.tvalid; one beat per cycle sustained.
// Backpressure: s_axis.tready is registered buffer-not-full; dropped beats never stall input.
// Ports: aclk/resetn; s_axis (slave stream in); m_axis (master stream out, tkeep all ones);
//        stat_clr clears sticky err_* flags and frame_cnt (complete frames forwarded, wraps).
module axis_vid_frame_aligner
  import axis_vid_frame_aligner_pkg::*;
#(
  parameter int DATA_WIDTH = VID_DATA_WIDTH,
  parameter int H_ACTIVE   = VID_H_ACTIVE,
  parameter int V_ACTIVE   = VID_V_ACTIVE
) (
  input  logic                            aclk,
  input  logic                            resetn,
  axis_vid_frame_aligner_if.slave         s_axis,
  axis_vid_frame_aligner_if.master        m_axis,
  input  logic                            stat_clr,
  output logic [15:0]                     frame_cnt,
  output logic                            err_sof_early,
  output logic                            err_sof_missing,
  output logic                            err_eol_early,
  output logic                            err_eol_late
);

  localparam int PIX_W     = vid_cnt_w(H_ACTIVE);
  localparam int LINE_W    = vid_cnt_w(V_ACTIVE);
  localparam int PAYLOAD_W = DATA_WIDTH + 2;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_ACTIVE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);

  vid_state_t          r_state;
  logic [PIX_W-1:0]    r_pix;
  logic [LINE_W-1:0]   r_line;
  logic [15:0]         r_frame_cnt;
  logic                r_err_sof_early;
  logic                r_err_sof_missing;
  logic                r_err_eol_early;
  logic                r_err_eol_late;

  logic                w_s_rdy;
  logic                w_acc;
  logic                w_at_origin;
  logic                w_fwd;
  logic                w_adv;
  logic                w_go_sync;
  logic                w_set_sof_early;
  logic                w_set_sof_missing;
  logic                w_set_eol_early;
  logic                w_set_eol_late;
  logic [PIX_W-1:0]    w_pos_pix;
  logic [LINE_W-1:0]   w_pos_line;
  logic                w_pos_sof;
  logic                w_pos_eol;
  logic                w_frame_done;
  logic [PIX_W-1:0]    w_nxt_pix;
  logic [LINE_W-1:0]   w_nxt_line;
  logic [PAYLOAD_W-1:0] w_in_dat;
  logic [PAYLOAD_W-1:0] w_out_dat;
  logic                w_unused_keep;

  // Input keep carries no information for a full-width pixel bus.
  assign w_unused_keep = ^s_axis.tkeep;

  assign w_acc       = s_axis.tvalid & w_s_rdy;
  assign w_at_origin = (r_pix == '0) && (r_line == '0);

  // Beat classification. w_pos_* is the grid position the beat is forwarded at:
  // any forwarded SOF beat restarts the grid at (0,0).
  always_comb begin
    w_fwd             = 1'b0;
    w_adv             = 1'b0;
    w_go_sync         = 1'b0;
    w_set_sof_early   = 1'b0;
    w_set_sof_missing = 1'b0;
    w_set_eol_early   = 1'b0;
    w_set_eol_late    = 1'b0;
    w_pos_pix         = r_pix;
    w_pos_line        = r_line;
    if (w_acc) begin
      if (r_state == ST_SYNC) begin
        if (s_axis.tuser) begin
          w_fwd      = 1'b1;
          w_adv      = 1'b1;
          w_pos_pix  = '0;
          w_pos_line = '0;
        end
      end else if (s_axis.tuser && !w_at_origin) begin
        // Truncate the running frame and restart on this beat.
        w_set_sof_early = 1'b1;
        w_fwd           = 1'b1;
        w_adv           = 1'b1;
        w_pos_pix       = '0;
        w_pos_line      = '0;
      end else if (!s_axis.tuser && w_at_origin) begin
        w_set_sof_missing = 1'b1;
        w_go_sync         = 1'b1;
      end else if (s_axis.tlast && (r_pix != PIX_LAST)) begin
        w_set_eol_early = 1'b1;
        w_go_sync       = 1'b1;
      end else if ((r_pix == PIX_LAST) && !s_axis.tlast) begin
        // The line is still correctly sized, so it goes out with tlast restored.
        w_set_eol_late = 1'b1;
        w_fwd          = 1'b1;
        w_adv          = 1'b1;
        w_go_sync      = 1'b1;
      end else begin
        w_fwd = 1'b1;
        w_adv = 1'b1;
      end
    end
  end

  assign w_pos_sof    = (w_pos_pix == '0) && (w_pos_line == '0);
  assign w_pos_eol    = (w_pos_pix == PIX_LAST);
  assign w_frame_done = w_adv && w_pos_eol && (w_pos_line == LINE_LAST);

  // Explicit wrap at the geometry limits; no reliance on counter overflow.
  always_comb begin
    w_nxt_pix  = w_pos_pix + PIX_W'(1);
    w_nxt_line = w_pos_line;
    if (w_pos_eol) begin
      w_nxt_pix  = '0;
      w_nxt_line = (w_pos_line == LINE_LAST) ? '0 : (w_pos_line + LINE_W'(1));
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state           <= ST_SYNC;
      r_pix             <= '0;
      r_line            <= '0;
      r_frame_cnt       <= 16'd0;
      r_err_sof_early   <= 1'b0;
      r_err_sof_missing <= 1'b0;
      r_err_eol_early   <= 1'b0;
      r_err_eol_late    <= 1'b0;
    end else begin
      if (w_go_sync) begin
        r_state <= ST_SYNC;
        r_pix   <= '0;
        r_line  <= '0;
      end else if (w_adv) begin
        r_state <= ST_PASS;
        r_pix   <= w_nxt_pix;
        r_line  <= w_nxt_line;
      end

      // Clear and increment together leave a count of one.
      if (stat_clr) begin
        r_frame_cnt <= w_frame_done ? 16'd1 : 16'd0;
      end else if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      // A new error in the clearing cycle wins over the clear.
      r_err_sof_early   <= (r_err_sof_early   & ~stat_clr) | w_set_sof_early;
      r_err_sof_missing <= (r_err_sof_missing & ~stat_clr) | w_set_sof_missing;
      r_err_eol_early   <= (r_err_eol_early   & ~stat_clr) | w_set_eol_early;
      r_err_eol_late    <= (r_err_eol_late    & ~stat_clr) | w_set_eol_late;
    end
  end

  assign w_in_dat = {w_pos_sof, w_pos_eol, s_axis.tdata};

  axis_skid_buf #(
    .W (PAYLOAD_W)
  ) u_skid (
    .aclk   (aclk),
    .resetn (resetn),
    .i_vld  (w_fwd),
    .i_dat  (w_in_dat),
    .o_rdy  (w_s_rdy),
    .o_vld  (m_axis.tvalid),
    .o_dat  (w_out_dat),
    .i_rdy  (m_axis.tready)
  );

  assign s_axis.tready = w_s_rdy;
  assign m_axis.tdata  = w_out_dat[DATA_WIDTH-1:0];
  assign m_axis.tlast  = w_out_dat[DATA_WIDTH];
  assign m_axis.tuser  = w_out_dat[DATA_WIDTH+1];
  assign m_axis.tkeep  = '1;

  assign frame_cnt       = r_frame_cnt;
  assign err_sof_early   = r_err_sof_early;
  assign err_sof_missing = r_err_sof_missing;
  assign err_eol_early   = r_err_eol_early;
  assign err_eol_late    = r_err_eol_late;

endmodule
